// File: rtl/axil_pkg.sv
// axil_pkg: shared FSM states and AXI-Lite response codes for the command master.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_BOTH,
        WR_DATA,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    localparam logic [1:0] AXI_OK  = 2'b00;
    localparam logic [1:0] AXI_ERR = 2'b10;

    // SLVERR and DECERR both carry bit 1; EXOKAY folds into success.
    function automatic logic is_err(input logic [1:0] resp);
        return (resp & AXI_ERR) != AXI_OK;
    endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns one simple read/write command at a time into AXI-Lite transactions.
// Define AXIL_MASTER_STATS_EN to add saturating write/read/error counters.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH = 8,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                    cmd_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_rdata,
    output logic                           rsp_err,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                           m_axi_lite_awvalid,
    input  logic                           m_axi_lite_awready,
    output logic [31:0]                    m_axi_lite_wdata,
    output logic                           m_axi_lite_wvalid,
    input  logic                           m_axi_lite_wready,
    input  logic [1:0]                     m_axi_lite_bresp,
    input  logic                           m_axi_lite_bvalid,
    output logic                           m_axi_lite_bready,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
    output logic                           m_axi_lite_arvalid,
    input  logic                           m_axi_lite_arready,
    input  logic [31:0]                    m_axi_lite_rdata,
    input  logic [1:0]                     m_axi_lite_rresp,
    input  logic                           m_axi_lite_rvalid,
    output logic                           m_axi_lite_rready
`ifdef AXIL_MASTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]           stat_wr_cnt,
    output logic [CNT_WIDTH-1:0]           stat_rd_cnt,
    output logic [CNT_WIDTH-1:0]           stat_err_cnt
`endif
);

    if (AXI_LITE_ADDR_WIDTH < 2 || CNT_WIDTH < 1) begin : g_bad_param
        $error("axil_cmd_master: AXI_LITE_ADDR_WIDTH must be >= 2 and CNT_WIDTH >= 1");
    end

    localparam logic [AXI_LITE_ADDR_WIDTH-1:0] WORD_MASK = ~AXI_LITE_ADDR_WIDTH'(3);

    state_t                         state, state_nxt;
    logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]                    wdata_q;
    logic [31:0]                    rdata_q;
    logic                           err_q;
    logic                           accept;
    logic                           wr_cap;
    logic                           rd_cap;

    assign accept = (state == IDLE) && cmd_valid;
    assign wr_cap = (state == WR_RESP) && m_axi_lite_bvalid;
    assign rd_cap = (state == RD_DATA) && m_axi_lite_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Valids and readies are pure state decodes, so no input reaches an output combinationally.
    always_comb begin
        state_nxt          = state;
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        m_axi_lite_awvalid = 1'b0;
        m_axi_lite_wvalid  = 1'b0;
        m_axi_lite_bready  = 1'b0;
        m_axi_lite_arvalid = 1'b0;
        m_axi_lite_rready  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = cmd_write ? WR_BOTH : RD_ADDR;
            end
            WR_BOTH: begin
                m_axi_lite_awvalid = 1'b1;
                m_axi_lite_wvalid  = 1'b1;
                if (m_axi_lite_awready && m_axi_lite_wready)
                    state_nxt = WR_RESP;
                else if (m_axi_lite_awready)
                    state_nxt = WR_DATA;
                else if (m_axi_lite_wready)
                    state_nxt = WR_ADDR;
            end
            WR_DATA: begin
                m_axi_lite_wvalid = 1'b1;
                if (m_axi_lite_wready)
                    state_nxt = WR_RESP;
            end
            WR_ADDR: begin
                m_axi_lite_awvalid = 1'b1;
                if (m_axi_lite_awready)
                    state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m_axi_lite_bready = 1'b1;
                if (m_axi_lite_bvalid)
                    state_nxt = RSP;
            end
            RD_ADDR: begin
                m_axi_lite_arvalid = 1'b1;
                if (m_axi_lite_arready)
                    state_nxt = RD_DATA;
            end
            RD_DATA: begin
                m_axi_lite_rready = 1'b1;
                if (m_axi_lite_rvalid)
                    state_nxt = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr & WORD_MASK;
                wdata_q <= cmd_wdata;
            end
            if (wr_cap) begin
                rdata_q <= '0;
                err_q   <= is_err(m_axi_lite_bresp);
            end
            if (rd_cap) begin
                rdata_q <= m_axi_lite_rdata;
                err_q   <= is_err(m_axi_lite_rresp);
            end
        end
    end

    assign m_axi_lite_awaddr = addr_q;
    assign m_axi_lite_araddr = addr_q;
    assign m_axi_lite_wdata  = wdata_q;
    assign rsp_rdata         = rdata_q;
    assign rsp_err           = err_q;

`ifdef AXIL_MASTER_STATS_EN
    logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt, err_cnt;
    logic                 err_cap;

    assign err_cap = (wr_cap && is_err(m_axi_lite_bresp)) || (rd_cap && is_err(m_axi_lite_rresp));

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (wr_cap && !(&wr_cnt))
                wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (rd_cap && !(&rd_cnt))
                rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            if (err_cap && !(&err_cnt))
                err_cnt <= err_cnt + CNT_WIDTH'(1);
        end
    end

    assign stat_wr_cnt  = wr_cnt;
    assign stat_rd_cnt  = rd_cnt;
    assign stat_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed bench with a small register-file AXI-Lite slave.
// Stats checks are active when AXIL_MASTER_STATS_EN is defined.
module tb_axil_cmd_master;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [31:0]   wdata;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;
`ifdef AXIL_MASTER_STATS_EN
    logic [15:0]   stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    int total = 0;
    int bad = 0;
    int aw_delay = 0;
    int b_hs_cnt = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    axil_cmd_master #(.AXI_LITE_ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready)
`ifdef AXIL_MASTER_STATS_EN
        ,
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    // Register-file slave: 64 words, reads of 0x20 answer SLVERR, awready can be held off.
    logic [31:0]   mem [64];
    logic          aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [31:0]   w_d;
    int            aw_wait;
    logic          aw_hs, w_hs, aw_have, w_have;
    logic [AW-1:0] wa;
    logic [31:0]   wd;

    assign awready = !aw_got && !bvalid && (aw_wait >= aw_delay);
    assign wready  = !w_got && !bvalid;
    assign arready = !rvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign wa      = aw_hs ? awaddr : aw_a;
    assign wd      = w_hs ? wdata : w_d;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_a    <= '0;
            w_d     <= '0;
            aw_wait <= 0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) aw_a <= awaddr;
            if (w_hs) w_d <= wdata;
            aw_wait <= aw_hs ? 0 : (awvalid ? aw_wait + 1 : 0);
            if (bvalid && bready) bvalid <= 1'b0;
            if (aw_have && w_have) begin
                mem[wa[7:2]] <= wd;
                bvalid <= 1'b1;
                bresp  <= 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_have;
                w_got  <= w_have;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[7:2]];
                rresp  <= (araddr == 8'h20) ? 2'b10 : 2'b00;
            end
        end
    end

    always @(posedge clk) begin
        if (bvalid && bready) b_hs_cnt <= b_hs_cnt + 1;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic apply_reset();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d, output int ok);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            ok = int'(cmd_ready);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 2;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int cyc);
        int ok;
        issue(w, a, d, ok);
        wait_rsp(cyc);
        if (ok == 0) cyc = -1;
        rd = rsp_rdata;
        er = rsp_err;
        take_rsp();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        total++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err});
        end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        total++; if ({awaddr, araddr, wdata} !== 48'h0) begin bad++; $display("FAIL reset_regs: got %h want 0", {awaddr, araddr, wdata}); end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        er;
        int          cyc, ok;
        xact(1'b1, 8'h04, 32'hDEADBEEF, rd, er, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL basic_wr_latency: got %0d want 4", cyc); end
        total++; if ({er, rd} !== 33'h0) begin bad++; $display("FAIL basic_wr_rsp: got err=%b rdata=%h want 0/0", er, rd); end
        total++; if (mem[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_wr_mem: got %h want deadbeef", mem[1]); end
        xact(1'b0, 8'h04, 32'h0, rd, er, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL basic_rd_latency: got %0d want 4", cyc); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL basic_rd_err: got %b want 0", er); end
        issue(1'b0, 8'h07, 32'h0, ok);
        total++; if ({arvalid, araddr} !== {1'b1, 8'h04}) begin bad++; $display("FAIL basic_addr_align: got v=%b a=%h want 1/04", arvalid, araddr); end
        wait_rsp(cyc);
        total++; if (rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_unaligned: got %h want deadbeef", rsp_rdata); end
        take_rsp();
    endtask

    task automatic test_aw_delay();
        int aw_hi, w_hi, unstable, ok, cyc;
        logic [31:0] rd;
        logic        er;
        aw_hi = 0; w_hi = 0; unstable = 0;
        aw_delay = 3;
        issue(1'b1, 8'h10, 32'h12345678, ok);
        total++; if ({awvalid, wvalid} !== 2'b11) begin bad++; $display("FAIL awdly_both: got %b want 11", {awvalid, wvalid}); end
        for (int i = 0; i < 20; i++) begin
            if (!awvalid && !wvalid) break;
            if (awvalid) begin aw_hi++; if (awaddr !== 8'h10) unstable++; end
            if (wvalid) begin w_hi++; if (wdata !== 32'h12345678) unstable++; end
            @(negedge clk);
        end
        total++; if (aw_hi !== 4) begin bad++; $display("FAIL awdly_aw_cycles: got %0d want 4", aw_hi); end
        total++; if (w_hi !== 1) begin bad++; $display("FAIL awdly_w_cycles: got %0d want 1", w_hi); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL awdly_payload: got %0d unstable want 0", unstable); end
        wait_rsp(cyc);
        total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL awdly_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        take_rsp();
        aw_delay = 0;
        xact(1'b0, 8'h10, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL awdly_readback: got %h want 12345678", rd); end
    endtask

    task automatic test_rsp_hold();
        logic [31:0] rd;
        logic        er;
        int          cyc, ok, a0;
        xact(1'b1, 8'h08, 32'hCAFEF00D, rd, er, cyc);
        issue(1'b0, 8'h08, 32'h0, ok);
        wait_rsp(cyc);
        a0 = acc_cnt;
        cmd_write = 1'b1;
        cmd_addr  = 8'h30;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
                bad++; $display("FAIL hold_rsp[%0d]: got v=%b d=%h want 1/cafef00d", i, rsp_valid, rsp_rdata);
            end
            total++; if ({cmd_ready, awvalid, wvalid, arvalid} !== 4'b0) begin
                bad++; $display("FAIL hold_quiet[%0d]: got %b want 0000", i, {cmd_ready, awvalid, wvalid, arvalid});
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        total++; if (acc_cnt - a0 !== 0) begin bad++; $display("FAIL hold_accepts: got %0d want 0", acc_cnt - a0); end
        take_rsp();
        total++; if ({cmd_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL hold_release: got %b want 10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_reset_rd_data();
        logic [31:0] rd;
        logic        er;
        int          cyc, ok;
        xact(1'b1, 8'h0C, 32'hA5A50001, rd, er, cyc);
        xact(1'b0, 8'h0C, 32'h0, rd, er, cyc);
        issue(1'b0, 8'h0C, 32'h0, ok);
        @(negedge clk);
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL rst_in_rd_data: got rready=%b want 1", rready); end
        #1 reset = 1'b1;
        #1;
        total++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err} !== 7'b0) begin
            bad++; $display("FAIL rst_async_ctrl: got %b want 0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err});
        end
        total++; if ({rsp_rdata, awaddr, araddr, wdata} !== 80'h0) begin
            bad++; $display("FAIL rst_async_regs: got d=%h aw=%h ar=%h w=%h want 0", rsp_rdata, awaddr, araddr, wdata);
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_async_idle: got %b want 1", cmd_ready); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        xact(1'b1, 8'h14, 32'h0BADF00D, rd, er, cyc);
        total++; if ({cyc, er} !== {32'd4, 1'b0}) begin bad++; $display("FAIL rst_after_wr: got cyc=%0d err=%b want 4/0", cyc, er); end
        xact(1'b0, 8'h14, 32'h0, rd, er, cyc);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL rst_after_rd: got %h want 0badf00d", rd); end
    endtask

    task automatic test_rd_err();
        logic [31:0] rd;
        logic        er;
        int          cyc;
        apply_reset();
        xact(1'b0, 8'h20, 32'h0, rd, er, cyc);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL rderr_err: got %b want 1", er); end
        total++; if (cyc !== 4) begin bad++; $display("FAIL rderr_latency: got %0d want 4", cyc); end
`ifdef AXIL_MASTER_STATS_EN
        total++; if (stat_err_cnt !== 16'd1) begin bad++; $display("FAIL rderr_stat_err: got %0d want 1", stat_err_cnt); end
        total++; if (stat_rd_cnt !== 16'd1) begin bad++; $display("FAIL rderr_stat_rd: got %0d want 1", stat_rd_cnt); end
        total++; if (stat_wr_cnt !== 16'd0) begin bad++; $display("FAIL rderr_stat_wr: got %0d want 0", stat_wr_cnt); end
`endif
        xact(1'b1, 8'h24, 32'h55AA55AA, rd, er, cyc);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL rderr_next_wr_err: got %b want 0", er); end
    endtask

    task automatic test_back_to_back();
        int a0, b0, n;
        apply_reset();
        a0 = acc_cnt;
        b0 = b_hs_cnt;
        rsp_ready = 1'b1;
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && (acc_cnt - a0) < 10; i++) begin
            n = acc_cnt - a0;
            cmd_addr  = 8'(n * 4);
            cmd_wdata = 32'h100 + 32'(n);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 50 && (b_hs_cnt - b0) < 10; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (acc_cnt - a0 !== 10) begin bad++; $display("FAIL b2b_accepts: got %0d want 10", acc_cnt - a0); end
        total++; if (b_hs_cnt - b0 !== 10) begin bad++; $display("FAIL b2b_b_handshakes: got %0d want 10", b_hs_cnt - b0); end
        total++; if ({mem[0], mem[9]} !== {32'h100, 32'h109}) begin bad++; $display("FAIL b2b_mem: got %h %h want 100 109", mem[0], mem[9]); end
`ifdef AXIL_MASTER_STATS_EN
        total++; if (stat_wr_cnt !== 16'd10) begin bad++; $display("FAIL b2b_stat_wr: got %0d want 10", stat_wr_cnt); end
        total++; if (stat_err_cnt !== 16'd0) begin bad++; $display("FAIL b2b_stat_err: got %0d want 0", stat_err_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_rsp_hold();
        test_reset_rd_data();
        test_rd_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
